hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core. Decides per-cycle stall/flush of the F/D, D/E, E/M
//  and M/W pipeline registers from decode operand usage, load-use hazards, decode-resolved

---
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencer with deferred fetch redirect
module hazard_ctrl #(
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [4:0]       d_ra1,
    input  logic [4:0]       d_ra2,
    input  logic             d_use1,
    input  logic             d_use2,
    input  logic             d_branch,
    input  logic [PC_W-1:0]  d_target,
    input  logic             e_valid,
    input  logic [4:0]       e_rd,
    input  logic             e_is_load,
    input  logic             i_busy,
    input  logic             m_busy,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_f,
    output logic             flush_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {RUN, REDIR_WAIT} state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  target_q, target_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             lu;

    // x0 is hardwired zero, so a load targeting it never blocks decode
    assign lu = d_valid & e_valid & e_is_load & (e_rd != 5'd0) &
                ((d_use1 & (d_ra1 == e_rd)) | (d_use2 & (d_ra2 == e_rd)));

    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        stall_f        = 1'b0;
        stall_d        = 1'b0;
        flush_f        = 1'b0;
        flush_d        = 1'b0;
        stall_e        = 1'b0;
        stall_m        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (m_busy) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        stall_m = 1'b1;
                    end else if (lu) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_d = 1'b1;
                    end else if (d_valid && d_branch) begin
                        flush_f = 1'b1;
                        if (i_busy) begin
                            stall_f  = 1'b1;
                            target_d = d_target;
                            state_d  = REDIR_WAIT;
                        end else begin
                            redirect_valid = 1'b1;
                            redirect_pc    = d_target;
                        end
                    end else if (i_busy) begin
                        stall_f = 1'b1;
                        flush_f = 1'b1;
                    end
                end
                REDIR_WAIT: begin
                    // PC stays put until the held redirect can actually be taken
                    flush_f = 1'b1;
                    stall_f = i_busy | m_busy;
                    stall_e = m_busy;
                    stall_m = m_busy;
                    if (!i_busy && !m_busy) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = target_q;
                        state_d        = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
        stall_cycles_d = stall_cycles_q + CNT_W'(stall_f);
        flush_count_d  = flush_count_q + CNT_W'(redirect_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            target_q       <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid, d_use1, d_use2, d_branch;
    logic [4:0]  d_ra1, d_ra2, e_rd;
    logic [63:0] d_target;
    logic        e_valid, e_is_load, i_busy, m_busy;
    logic        stall_f, stall_d, flush_f, flush_d, stall_e, stall_m, redirect_valid;
    logic [63:0] redirect_pc;
    logic [31:0] stall_cycles, flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.PC_W(64), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .d_valid(d_valid), .d_ra1(d_ra1), .d_ra2(d_ra2),
        .d_use1(d_use1), .d_use2(d_use2),
        .d_branch(d_branch), .d_target(d_target),
        .e_valid(e_valid), .e_rd(e_rd), .e_is_load(e_is_load),
        .i_busy(i_busy), .m_busy(m_busy),
        .stall_f(stall_f), .stall_d(stall_d), .flush_f(flush_f), .flush_d(flush_d),
        .stall_e(stall_e), .stall_m(stall_m),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one cycle; inputs change 1ns after the edge, checks happen mid-cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // {stall_f, stall_d, flush_f, flush_d, stall_e, stall_m, redirect_valid}
    task automatic check_ctl(input string tag, input logic [6:0] exp);
        check(tag, {57'd0, stall_f, stall_d, flush_f, flush_d, stall_e, stall_m, redirect_valid},
              {57'd0, exp});
    endtask

    task automatic idle_inputs();
        d_valid = 1'b1; d_ra1 = 5'd0; d_ra2 = 5'd0; d_use1 = 1'b0; d_use2 = 1'b0;
        d_branch = 1'b0; d_target = 64'd0;
        e_valid = 1'b0; e_rd = 5'd0; e_is_load = 1'b0;
        i_busy = 1'b0; m_busy = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        settle();
        check_ctl("reset_ctl", 7'b0000000);
        check("reset_pc", redirect_pc, 64'd0);
        check("reset_stall_cnt", {32'd0, stall_cycles}, 64'd0);
        check("reset_flush_cnt", {32'd0, flush_count}, 64'd0);
        reset = 1'b0;
        tick();

        // load-use on ra1
        e_valid = 1'b1; e_is_load = 1'b1; e_rd = 5'd5; d_ra1 = 5'd5; d_use1 = 1'b1;
        settle();
        check_ctl("lu_ra1", 7'b1101000);
        tick();
        e_valid = 1'b0;
        settle();
        check_ctl("lu_bubble_done", 7'b0000000);
        check("lu_stall_cnt", {32'd0, stall_cycles}, 64'd1);

        // x0 and unused operand never hazard
        e_valid = 1'b1; e_rd = 5'd0; d_ra1 = 5'd0;
        settle();
        check_ctl("lu_x0", 7'b0000000);
        e_rd = 5'd5; d_ra1 = 5'd5; d_use1 = 1'b0;
        settle();
        check_ctl("lu_unused", 7'b0000000);
        d_ra2 = 5'd5; d_use2 = 1'b1;
        settle();
        check_ctl("lu_ra2", 7'b1101000);
        tick();
        idle_inputs();
        settle();
        check("lu_ra2_cnt", {32'd0, stall_cycles}, 64'd2);

        // immediate branch redirect
        d_branch = 1'b1; d_target = 64'h8000_0040;
        settle();
        check_ctl("br_now", 7'b0010001);
        check("br_now_pc", redirect_pc, 64'h8000_0040);
        tick();
        d_branch = 1'b0;
        settle();
        check_ctl("br_now_after", 7'b0000000);
        check("br_now_cnt", {32'd0, flush_count}, 64'd1);

        // deferred redirect while ibus busy for 3 cycles
        d_branch = 1'b1; d_target = 64'h8000_0100; i_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            check_ctl($sformatf("br_wait_%0d", c), 7'b1010000);
            tick();
            d_branch = 1'b0; d_target = 64'h0;
        end
        i_busy = 1'b0;
        settle();
        check_ctl("br_wait_fire", 7'b0010001);
        check("br_wait_pc", redirect_pc, 64'h8000_0100);
        tick();
        settle();
        check_ctl("br_wait_pulse", 7'b0000000);
        check("br_wait_fcnt", {32'd0, flush_count}, 64'd2);
        check("br_wait_scnt", {32'd0, stall_cycles}, 64'd5);

        // mem stall dominates load-use and branch
        m_busy = 1'b1; e_valid = 1'b1; e_is_load = 1'b1; e_rd = 5'd7;
        d_ra1 = 5'd7; d_use1 = 1'b1; d_branch = 1'b1; d_target = 64'h8000_0200;
        for (int c = 0; c < 5; c++) begin
            settle();
            check_ctl($sformatf("mem_%0d", c), 7'b1100110);
            tick();
        end
        m_busy = 1'b0;
        settle();
        check_ctl("mem_then_lu", 7'b1101000);
        tick();
        e_valid = 1'b0;
        settle();
        check_ctl("mem_then_br", 7'b0010001);
        check("mem_then_br_pc", redirect_pc, 64'h8000_0200);
        tick();
        idle_inputs();
        settle();
        check("mem_fcnt", {32'd0, flush_count}, 64'd3);
        check("mem_scnt", {32'd0, stall_cycles}, 64'd11);

        // reset during REDIR_WAIT discards the latched target
        d_branch = 1'b1; d_target = 64'h8000_0300; i_busy = 1'b1;
        tick();
        d_branch = 1'b0;
        reset = 1'b1;
        settle();
        check_ctl("rst_wait_ctl", 7'b0000000);
        tick();
        reset = 1'b0; i_busy = 1'b0;
        settle();
        check_ctl("rst_wait_after", 7'b0000000);
        check("rst_wait_pc", redirect_pc, 64'd0);
        check("rst_wait_fcnt", {32'd0, flush_count}, 64'd0);
        tick();
        settle();
        check_ctl("rst_wait_later", 7'b0000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
